// File: rtl/sw_debounce_pkg.sv
// Board-level timing constants shared by the switch/button conditioning logic.
package sw_debounce_pkg;
  localparam int CLK_HZ            = 100_000_000;
  localparam int DEBOUNCE_MS       = 10;
  localparam int DEF_STABLE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DEF_CNT_W         = 20;
endpackage

// File: rtl/debounce_cell.sv
// One debounced channel: 2-flop synchronizer, stability counter, clean level
// and single-cycle rise/fall pulses registered alongside the level flip.
module debounce_cell
  import sw_debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   CNT_W         = DEF_CNT_W,
  parameter logic INIT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= INIT;
      sync2 <= INIT;
      level <= INIT;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      // Any agreement with the clean level restarts the window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sw_debounce.sv
// N independent debounce channels sharing one clock; each channel is a debounce_cell.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int   N             = 1,
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   CNT_W         = DEF_CNT_W,
  parameter logic INIT          = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);
  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_cell #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W),
      .INIT         (INIT)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end
endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (N=2, STABLE_CYCLES=4): stimulus queues expected
// pulse events, a negedge monitor pops and checks them whenever a pulse appears.
module tb_sw_debounce;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] raw = 2'b11;
  logic [1:0] level, rise, fall;

  sw_debounce #(.N(2), .STABLE_CYCLES(4), .CNT_W(3), .INIT(1'b0)) dut (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] level;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called at the negedge after edge c; event expected after edge c+lat.
  task automatic expect_ev(input int lat, input logic [1:0] r, input logic [1:0] f,
                           input logic [1:0] l);
    ev_t e;
    e.cyc   = cyc + lat;
    e.rise  = r;
    e.fall  = f;
    e.level = l;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if ((rise | fall) != 2'b00) begin
      chk("rise_fall_exclusive", int'(rise & fall), 0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got rise=%b fall=%b expected none (cycle %0d)",
                 rise, fall, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("pulse_cycle", cyc, mon_e.cyc);
        chk("pulse_rise", int'(rise), int'(mon_e.rise));
        chk("pulse_fall", int'(fall), int'(mon_e.fall));
        chk("pulse_level", int'(level), int'(mon_e.level));
      end
    end
  end

  initial begin
    // Reset held with raw=11.
    step(3);
    chk("reset_level", int'(level), 0);
    chk("reset_rise", int'(rise), 0);
    chk("reset_fall", int'(fall), 0);
    rst = 1'b1;
    expect_ev(6, 2'b11, 2'b00, 2'b11);
    step(8);
    chk("post_reset_level", int'(level), 3);

    // Asynchronous reset mid-cycle clears level with no clock edge.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_reset_level", int'(level), 0);
    chk("async_reset_rise", int'(rise), 0);
    raw = 2'b00;
    step(2);
    rst = 1'b1;
    step(8);
    chk("idle_level", int'(level), 0);

    // Clean step on channel 0.
    raw = 2'b01;
    expect_ev(6, 2'b01, 2'b00, 2'b01);
    step(8);

    // Bring channel 1 high, then a 3-cycle glitch low must be rejected.
    raw = 2'b11;
    expect_ev(6, 2'b10, 2'b00, 2'b11);
    step(8);
    raw = 2'b01;
    step(3);
    raw = 2'b11;
    step(8);
    chk("glitch_level", int'(level), 3);

    // Channel 0 back to 0, then bounce with 2-cycle periods before holding 1.
    raw = 2'b10;
    expect_ev(6, 2'b00, 2'b01, 2'b10);
    step(8);
    for (int i = 0; i < 4; i++) begin
      raw[0] = (i % 2 == 0);
      step(2);
    end
    chk("bounce_level", int'(level), 2);
    raw[0] = 1'b1;
    expect_ev(6, 2'b01, 2'b00, 2'b11);
    step(8);

    // Reset two cycles into a qualification window on channel 0.
    raw = 2'b10;
    expect_ev(6, 2'b00, 2'b01, 2'b10);
    step(8);
    raw = 2'b11;
    step(2);
    rst = 1'b0;
    #1 chk("midwin_reset_level", int'(level), 0);
    step(2);
    rst = 1'b1;
    expect_ev(6, 2'b11, 2'b00, 2'b11);
    step(8);

    // Both channels flip together, down then up.
    raw = 2'b00;
    expect_ev(6, 2'b00, 2'b11, 2'b00);
    step(8);
    raw = 2'b11;
    expect_ev(6, 2'b11, 2'b00, 2'b11);
    step(8);
    chk("final_level", int'(level), 3);

    // Every queued pulse must have been observed.
    chk("pending_events", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
